// File: rtl/pixel_adjust_ctrl_pkg.sv
// Shared types and constants for the pixel colour-adjust front-panel controller.
package pixel_adjust_ctrl_pkg;

   localparam int unsigned LVL_W         = 4;
   localparam int unsigned MODE_W        = 2;
   localparam int unsigned MAX_LEVEL_DEF = 15;

   localparam int unsigned KEY_ADD_LUM = 0;
   localparam int unsigned KEY_SUB_LUM = 1;
   localparam int unsigned KEY_ADD_SAT = 2;
   localparam int unsigned KEY_SUB_SAT = 3;
   localparam int unsigned KEY_MODE    = 4;
   localparam int unsigned NUM_KEYS    = 5;

   localparam logic [MODE_W-1:0] MODE_RAW  = 2'b00;
   localparam logic [MODE_W-1:0] MODE_GRAY = 2'b01;
   localparam logic [MODE_W-1:0] MODE_SKIN = 2'b10;
   localparam logic [MODE_W-1:0] MODE_IR   = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HOLD_DLY,
      HOLD_RPT,
      REL_DB
   } key_state_e;

   // Saturating +/-1; opposing requests in the same cycle cancel.
   function automatic logic [LVL_W-1:0] step_level(input logic [LVL_W-1:0] v,
                                                   input logic inc,
                                                   input logic dec,
                                                   input logic [LVL_W-1:0] max_lvl);
      logic [LVL_W-1:0] r;
      r = v;
      if (inc && !dec && (v < max_lvl)) r = v + LVL_W'(1);
      if (dec && !inc && (v != '0))     r = v - LVL_W'(1);
      return r;
   endfunction

endpackage

// File: rtl/pixel_adjust_ctrl_key_conditioner.sv
// One push-button: 2-FF sync, debounce, hold-to-repeat; emits a one-cycle step pulse.
module key_conditioner
   import pixel_adjust_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 50000,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000,
   parameter int unsigned CNT_W        = 25,
   parameter bit          REPEAT_EN    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic step
);

   // The cycle that first sees the new level counts as the first stable cycle.
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 2);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);

   logic             key_s1, key_s;
   key_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             step_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_s1 <= 1'b1;
         key_s  <= 1'b1;
         state  <= IDLE;
         cnt    <= '0;
         step   <= 1'b0;
      end else begin
         key_s1 <= key;
         key_s  <= key_s1;
         state  <= state_nx;
         cnt    <= cnt_nx;
         step   <= step_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CNT_W'(1);
      step_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (!key_s) state_nx = PRESS_DB;
         end
         PRESS_DB: begin
            if (key_s) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == DB_LAST) begin
               step_nx  = 1'b1;
               state_nx = HOLD_DLY;
               cnt_nx   = '0;
            end
         end
         HOLD_DLY: begin
            if (key_s) begin
               state_nx = REL_DB;
               cnt_nx   = '0;
            end else if (cnt == DLY_LAST) begin
               step_nx  = REPEAT_EN;
               state_nx = HOLD_RPT;
               cnt_nx   = '0;
            end
         end
         HOLD_RPT: begin
            if (key_s) begin
               state_nx = REL_DB;
               cnt_nx   = '0;
            end else if (cnt == RPT_LAST) begin
               step_nx = REPEAT_EN;
               cnt_nx  = '0;
            end
         end
         REL_DB: begin
            // A re-press during release debounce resumes holding without a new step.
            if (!key_s) begin
               state_nx = HOLD_DLY;
               cnt_nx   = '0;
            end else if (cnt == DB_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: rtl/pixel_adjust_ctrl.sv
// Front-panel controller: shadow luminance/saturation/mode, committed atomically at frame start.
module pixel_adjust_ctrl
   import pixel_adjust_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 50000,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000,
   parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEF,
   parameter int unsigned CNT_W        = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iKey_add_lum,
   input  logic              iKey_sub_lum,
   input  logic              iKey_add_sat,
   input  logic              iKey_sub_sat,
   input  logic              iKey_mode,
   input  logic              iVS,
   output logic [LVL_W-1:0]  oLuminance,
   output logic [LVL_W-1:0]  oSaturation,
   output logic [MODE_W-1:0] oMode,
   output logic              oPending
);

   localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVEL);

   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] step;

   assign key_raw = {iKey_mode, iKey_sub_sat, iKey_add_sat, iKey_sub_lum, iKey_add_lum};

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_conditioner #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE),
         .CNT_W        (CNT_W),
         .REPEAT_EN    (i != KEY_MODE)
      ) u_key (
         .clk  (clk),
         .rst  (rst),
         .key  (key_raw[i]),
         .step (step[i])
      );
   end

   logic              vs_s1, vs_s2, vs_s3;
   logic              vs_fall_c;
   logic [LVL_W-1:0]  lum_sh, sat_sh, lum_sh_nx, sat_sh_nx, lum_nx, sat_nx;
   logic [MODE_W-1:0] mode_sh, mode_sh_nx, mode_nx;
   logic              pending_nx;

   assign vs_fall_c = vs_s3 & ~vs_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_s1       <= 1'b1;
         vs_s2       <= 1'b1;
         vs_s3       <= 1'b1;
         lum_sh      <= '0;
         sat_sh      <= '0;
         mode_sh     <= MODE_RAW;
         oLuminance  <= '0;
         oSaturation <= '0;
         oMode       <= MODE_RAW;
         oPending    <= 1'b0;
      end else begin
         vs_s1       <= iVS;
         vs_s2       <= vs_s1;
         vs_s3       <= vs_s2;
         lum_sh      <= lum_sh_nx;
         sat_sh      <= sat_sh_nx;
         mode_sh     <= mode_sh_nx;
         oLuminance  <= lum_nx;
         oSaturation <= sat_nx;
         oMode       <= mode_nx;
         oPending    <= pending_nx;
      end
   end

   // Commit captures pre-step shadow; pending tracks the post-edge register values.
   always_comb begin
      lum_sh_nx  = step_level(lum_sh, step[KEY_ADD_LUM], step[KEY_SUB_LUM], MAX_LVL);
      sat_sh_nx  = step_level(sat_sh, step[KEY_ADD_SAT], step[KEY_SUB_SAT], MAX_LVL);
      mode_sh_nx = step[KEY_MODE] ? mode_sh + MODE_W'(1) : mode_sh;
      lum_nx     = oLuminance;
      sat_nx     = oSaturation;
      mode_nx    = oMode;
      if (vs_fall_c) begin
         lum_nx  = lum_sh;
         sat_nx  = sat_sh;
         mode_nx = mode_sh;
      end
      pending_nx = (lum_sh_nx != lum_nx) || (sat_sh_nx != sat_nx) || (mode_sh_nx != mode_nx);
   end

endmodule

// File: tb/tb_pixel_adjust_ctrl.sv
// Directed bench for pixel_adjust_ctrl with a run-length behavioural model checked every cycle.
module tb_pixel_adjust_ctrl;

   localparam int DB    = 4;
   localparam int DLY   = 16;
   localparam int RATE  = 8;
   localparam int MAXL  = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] key_n;   // 0 add_lum, 1 sub_lum, 2 add_sat, 3 sub_sat, 4 mode
   logic       vs;
   logic [3:0] lum, sat;
   logic [1:0] mode;
   logic       pend;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pixel_adjust_ctrl #(
      .DEBOUNCE_CYC (DB),
      .REPEAT_DELAY (DLY),
      .REPEAT_RATE  (RATE),
      .MAX_LEVEL    (MAXL),
      .CNT_W        (25)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .iKey_add_lum (key_n[0]),
      .iKey_sub_lum (key_n[1]),
      .iKey_add_sat (key_n[2]),
      .iKey_sub_sat (key_n[3]),
      .iKey_mode    (key_n[4]),
      .iVS          (vs),
      .oLuminance   (lum),
      .oSaturation  (sat),
      .oMode        (mode),
      .oPending     (pend)
   );

   // Model: keys as run lengths of the 2-cycle-delayed level; settings as plain integers.
   int m_d1 [5], m_d2 [5], m_pulse [5];
   int m_acc [5], m_low [5], m_high [5], m_hold [5];
   int m_lum, m_sat, m_mode, m_clum, m_csat, m_cmode;
   int m_vs1, m_vs2, m_vs3, m_syn;

   function automatic int lvl(input int v, input int inc, input int dec);
      int r;
      r = v + inc - dec;
      if (r < 0) r = 0;
      if (r > MAXL) r = MAXL;
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 5; k++) begin
            m_d1[k] = 1; m_d2[k] = 1; m_pulse[k] = 0;
            m_acc[k] = 0; m_low[k] = 0; m_high[k] = 0; m_hold[k] = 0;
         end
         m_lum = 0; m_sat = 0; m_mode = 0; m_clum = 0; m_csat = 0; m_cmode = 0;
         m_vs1 = 1; m_vs2 = 1; m_vs3 = 1;
      end else begin
         if (m_vs3 == 1 && m_vs2 == 0) begin
            m_clum = m_lum; m_csat = m_sat; m_cmode = m_mode;
         end
         m_lum  = lvl(m_lum, m_pulse[0], m_pulse[1]);
         m_sat  = lvl(m_sat, m_pulse[2], m_pulse[3]);
         m_mode = (m_mode + m_pulse[4]) % 4;
         m_vs3 = m_vs2; m_vs2 = m_vs1; m_vs1 = int'(vs);
         for (int k = 0; k < 5; k++) begin
            m_syn = m_d2[k];
            m_d2[k] = m_d1[k];
            m_d1[k] = int'(key_n[k]);
            m_pulse[k] = 0;
            if (m_syn == 0) begin
               if (m_acc[k] == 0) begin
                  m_low[k]++;
                  if (m_low[k] == DB) begin
                     m_pulse[k] = 1; m_acc[k] = 1; m_hold[k] = 0; m_high[k] = 0; m_low[k] = 0;
                  end
               end else if (m_high[k] > 0) begin
                  m_high[k] = 0; m_hold[k] = 0;
               end else begin
                  m_hold[k]++;
                  if (k != 4 && m_hold[k] >= DLY && (m_hold[k] - DLY) % RATE == 0) m_pulse[k] = 1;
               end
            end else begin
               if (m_acc[k] == 0) m_low[k] = 0;
               else begin
                  m_high[k]++;
                  if (m_high[k] == DB) begin
                     m_acc[k] = 0; m_high[k] = 0; m_low[k] = 0;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("model_lum",  int'(lum),  m_clum);
      check("model_sat",  int'(sat),  m_csat);
      check("model_mode", int'(mode), m_cmode);
      check("model_pend", int'(pend),
            (m_lum != m_clum || m_sat != m_csat || m_mode != m_cmode) ? 1 : 0);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (rst) compare_model();
      end
   endtask

   task automatic press(input int k, input int hold);
      key_n[k] = 1'b0;
      tick(hold);
      key_n[k] = 1'b1;
      tick(12);
   endtask

   task automatic commit();
      vs = 1'b0;
      tick(4);
      vs = 1'b1;
      tick(4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b0;
      key_n = 5'b11111;
      vs    = 1'b1;
      tick(3);
      check("rst_lum", int'(lum), 0);
      check("rst_sat", int'(sat), 0);
      check("rst_mode", int'(mode), 0);
      check("rst_pend", int'(pend), 0);
      #3 rst = 1'b1;
      tick(2);

      // Three clean presses, then one frame start.
      for (int i = 0; i < 3; i++) press(0, 10);
      check("lum_pre_commit", int'(lum), 0);
      check("pend_pre_commit", int'(pend), 1);
      vs = 1'b0;
      tick(2);
      check("lum_commit_lat2", int'(lum), 0);
      tick(1);
      check("lum_commit_lat3", int'(lum), 3);
      check("pend_post_commit", int'(pend), 0);
      vs = 1'b1;
      tick(4);

      // Bounce rejected, then a real press with its exact step latency.
      key_n[2] = 1'b0; tick(3); key_n[2] = 1'b1; tick(12);
      check("bounce_pend", int'(pend), 0);
      key_n[2] = 1'b0;
      tick(6);
      check("step_lat_before", int'(pend), 0);
      tick(1);
      check("step_lat_after", int'(pend), 1);
      tick(3); key_n[2] = 1'b1; tick(12);
      commit();
      check("sat_one", int'(sat), 1);

      // Auto-repeat down to zero, clamped.
      press(1, 10);
      commit();
      check("lum_two", int'(lum), 2);
      key_n[1] = 1'b0;
      tick(7);
      check("sub_hold_pend", int'(pend), 1);
      tick(33);
      key_n[1] = 1'b1;
      tick(12);
      commit();
      check("lum_clamp_zero", int'(lum), 0);
      check("pend_zero", int'(pend), 0);

      // Climb to 14, then hold to clamp at 15, then cancelling pair.
      for (int i = 0; i < 14; i++) press(0, 10);
      commit();
      check("lum_14", int'(lum), 14);
      press(0, 60);
      commit();
      check("lum_clamp_max", int'(lum), 15);
      key_n[0] = 1'b0; key_n[1] = 1'b0;
      tick(10);
      key_n[0] = 1'b1; key_n[1] = 1'b1;
      tick(12);
      check("cancel_pend", int'(pend), 0);
      commit();
      check("cancel_lum", int'(lum), 15);

      // Mode wraps and ignores repeat.
      for (int i = 0; i < 5; i++) press(4, 10);
      commit();
      check("mode_gray", int'(mode), 1);
      press(4, 40);
      commit();
      check("mode_no_repeat", int'(mode), 2);

      // Step pulse coincident with frame-start detect.
      key_n[2] = 1'b0;
      tick(4);
      vs = 1'b0;
      tick(3);
      check("coincide_sat_old", int'(sat), 1);
      check("coincide_pend", int'(pend), 1);
      vs = 1'b1;
      tick(3);
      key_n[2] = 1'b1;
      tick(12);
      commit();
      check("coincide_sat_new", int'(sat), 2);

      // Reset while a key is held, then a full debounce after release.
      key_n[2] = 1'b0;
      tick(20);
      #3 rst = 1'b0;
      #1;
      check("midrst_lum", int'(lum), 0);
      check("midrst_sat", int'(sat), 0);
      check("midrst_mode", int'(mode), 0);
      check("midrst_pend", int'(pend), 0);
      @(negedge clk);
      #3 rst = 1'b1;
      tick(6);
      check("rel_rst_before", int'(pend), 0);
      tick(1);
      check("rel_rst_after", int'(pend), 1);
      key_n[2] = 1'b1;
      tick(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
